// File: rtl/sim_uart_ctrl.sv
// Simulation console / finish device: request/response slave feeding a TX FIFO
// that drains one character per output slot, ending with a single finish beat.
module sim_uart_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int TX_GAP     = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              uart_out_valid,
    output logic [7:0]        uart_out_ch
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_HALT} state_t;

    state_t          r_state, w_next;
    logic [6:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic [GW-1:0]   r_gap;
    logic [6:0]      r_code;
    logic            r_live;
    logic            r_resp_valid;
    logic [31:0]     r_rdata;
    logic            r_out_valid;
    logic [7:0]      r_out_ch;

    logic [1:0]      w_sel;
    logic            w_full, w_empty, w_push_blk, w_acc, w_push, w_fin, w_pop, w_beat;
    logic [31:0]     w_status, w_rdata;
    logic            w_unused;

    assign w_sel      = req_addr[3:2];
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    // A pop in the same cycle does not make room for a push to a full FIFO.
    assign w_push_blk = req_valid && req_wen && (w_sel == 2'd0) && w_full;
    assign req_ready  = r_live && (r_state == S_RUN) && !r_resp_valid && !w_push_blk;
    assign w_acc      = req_valid && req_ready;
    assign w_push     = w_acc && req_wen && (w_sel == 2'd0);
    assign w_fin      = w_acc && req_wen && (w_sel == 2'd2);
    assign w_pop      = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !w_empty && (r_gap == '0);
    assign w_unused   = ^{req_wdata[31:7], req_addr};

    assign w_status = {16'h0, 8'(r_count), 5'b0, (r_state != S_RUN), w_empty, w_full};
    assign w_rdata  = (!req_wen && (w_sel == 2'd1)) ? w_status : 32'h0;

    always_comb begin
        w_next = r_state;
        w_beat = 1'b0;
        case (r_state)
            S_RUN:   if (w_fin) w_next = S_DRAIN;
            S_DRAIN: if (w_empty && (r_gap == '0)) begin
                         w_next = S_DONE;
                         w_beat = 1'b1;
                     end
            S_DONE:  w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= req_wdata[6:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_gap        <= '0;
            r_code       <= '0;
            r_live       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_out_valid  <= 1'b0;
            r_out_ch     <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Gap counter idles at 0; each emitted character reloads it.
            if (w_pop)               r_gap <= GW'(TX_GAP);
            else if (r_gap != '0)    r_gap <= r_gap - GW'(1);
            if (w_fin) r_code <= req_wdata[6:0];
            if (w_acc) begin
                r_resp_valid <= 1'b1;
                r_rdata      <= w_rdata;
            end else if (r_resp_valid && resp_ready) begin
                r_resp_valid <= 1'b0;
                r_rdata      <= '0;
            end
            r_out_valid <= w_pop || w_beat;
            if (w_pop)       r_out_ch <= {1'b0, r_mem[r_rptr]};
            else if (w_beat) r_out_ch <= {1'b1, r_code};
            else             r_out_ch <= '0;
        end
    end

    assign resp_valid     = r_resp_valid;
    assign resp_rdata     = r_rdata;
    assign uart_out_valid = r_out_valid;
    assign uart_out_ch    = r_out_ch;
endmodule

// File: tb/tb_sim_uart_ctrl.sv
// Bench for sim_uart_ctrl: three instances (TX_GAP 0/20/2) checked against an
// expected-beat array and an occupancy model derived from observed strobes.
module tb_sim_uart_ctrl;
    localparam int NI = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [NI-1:0]       req_valid, req_ready, req_wen, resp_valid, resp_ready, uv;
    logic [NI-1:0][3:0]  req_addr;
    logic [NI-1:0][31:0] req_wdata, resp_rdata;
    logic [NI-1:0][7:0]  uch;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_mem [NI][512];
    int  wr_n [NI];
    int  rd_n [NI];
    int  strobes [NI];
    int  stamp [NI][64];
    bit  fin [NI];
    bit  beat_seen [NI];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int G = (g == 0) ? 0 : (g == 1) ? 20 : 2;
        sim_uart_ctrl #(.FIFO_DEPTH(16), .ADDR_W(4), .TX_GAP(G)) u_dut (
            .clock(clock), .reset(reset),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_wen(req_wen[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]), .resp_rdata(resp_rdata[g]),
            .uart_out_valid(uv[g]), .uart_out_ch(uch[g])
        );
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_of(int i);
        int occ;
        occ = wr_n[i] - rd_n[i];
        return {16'h0, occ[7:0], 5'b0, fin[i], (occ == 0), (occ == 16)};
    endfunction

    // Every strobe must match the next expected beat in order.
    always @(negedge clock) begin
        for (int i = 0; i < NI; i++) begin
            if (uv[i] === 1'b1) begin
                if (rd_n[i] >= wr_n[i]) chk($sformatf("spurious_strobe%0d", i), {31'b0, uv[i]}, 32'h0);
                else begin
                    chk($sformatf("strobe_ch%0d", i), {24'h0, uch[i]}, {24'h0, exp_mem[i][rd_n[i] % 512]});
                    rd_n[i]++;
                end
                if (uch[i][7]) beat_seen[i] = 1'b1;
                stamp[i][strobes[i] % 64] = cyc;
                strobes[i]++;
            end
        end
    end

    int acc_cyc [NI];

    task automatic do_req(int i, bit wen, logic [3:0] addr, logic [31:0] wd, int hold);
        int n;
        logic [31:0] exp;
        req_valid[i] = 1'b1; req_wen[i] = wen; req_addr[i] = addr; req_wdata[i] = wd;
        resp_ready[i] = (hold == 0);
        #1;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 200) begin
            @(negedge clock); #1; n++;
        end
        if (n >= 200) begin
            chk("req_timeout", {31'b0, req_ready[i]}, 32'h1);
            req_valid[i] = 1'b0; resp_ready[i] = 1'b1;
            return;
        end
        exp = (!wen && addr[3:2] == 2'd1) ? status_of(i) : 32'h0;
        if (wen && addr[3:2] == 2'd0) begin
            exp_mem[i][wr_n[i] % 512] = {1'b0, wd[6:0]}; wr_n[i]++;
        end else if (wen && addr[3:2] == 2'd2) begin
            exp_mem[i][wr_n[i] % 512] = {1'b1, wd[6:0]}; wr_n[i]++; fin[i] = 1'b1;
        end
        acc_cyc[i] = cyc + 1;
        @(posedge clock); #1;
        req_valid[i] = 1'b0;
        chk("resp_valid_rise", {31'b0, resp_valid[i]}, 32'h1);
        chk("resp_rdata", resp_rdata[i], exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            chk("resp_hold_valid", {31'b0, resp_valid[i]}, 32'h1);
            chk("resp_hold_rdata", resp_rdata[i], exp);
        end
        resp_ready[i] = 1'b1;
        @(posedge clock); #1;
        chk("resp_clear", {31'b0, resp_valid[i]}, 32'h0);
        @(negedge clock); #1;
    endtask

    task automatic flush_model();
        for (int i = 0; i < NI; i++) begin
            rd_n[i] = wr_n[i]; fin[i] = 1'b0; beat_seen[i] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, snap, hi, p0;
        bit stalled, seen;
        req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0; resp_ready = '1;
        for (int i = 0; i < NI; i++) begin
            wr_n[i] = 0; rd_n[i] = 0; strobes[i] = 0; fin[i] = 0; beat_seen[i] = 0;
        end

        // 1: reset state, ready one edge after release, register map basics
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        chk("rst_req_ready", {29'b0, req_ready}, 32'h0);
        chk("rst_resp_valid", {29'b0, resp_valid}, 32'h0);
        chk("rst_uart_valid", {29'b0, uv}, 32'h0);
        chk("rst_uart_ch", {8'h0, uch}, 32'h0);
        for (int i = 0; i < NI; i++) chk("rst_rdata", resp_rdata[i], 32'h0);
        reset = 1'b0; #1;
        chk("ready_before_edge", {29'b0, req_ready}, 32'h0);
        @(negedge clock); #1;
        chk("ready_after_edge", {29'b0, req_ready}, 32'h7);
        do_req(0, 1'b0, 4'h4, 32'h0, 0);
        do_req(0, 1'b0, 4'h0, 32'h0, 0);
        do_req(0, 1'b1, 4'hC, $urandom, 0);
        do_req(0, 1'b0, 4'hC, 32'h0, 3);
        do_req(0, 1'b0, 4'h4, 32'h0, 2);

        // 2: two characters, one-cycle latency, bit7 masked
        snap = strobes[0];
        do_req(0, 1'b1, 4'h0, 32'h48, 0);
        chk("lat_48", stamp[0][(strobes[0] - 1) % 64], acc_cyc[0] + 1);
        do_req(0, 1'b1, 4'h0, 32'h69, 0);
        chk("lat_69", stamp[0][(strobes[0] - 1) % 64], acc_cyc[0] + 1);
        do_req(0, 1'b1, 4'h0, 32'hC8, 0);
        chk("strobe_count_t2", strobes[0], snap + 3);

        // 4: TX_GAP=2, strobes exactly 3 cycles apart
        snap = strobes[2];
        for (int k = 0; k < 3; k++) do_req(2, 1'b1, 4'h0, $urandom, 0);
        repeat (12) @(negedge clock); #1;
        chk("gap_count", strobes[2], snap + 3);
        chk("gap_d1", stamp[2][(snap + 1) % 64] - stamp[2][snap % 64], 3);
        chk("gap_d2", stamp[2][(snap + 2) % 64] - stamp[2][(snap + 1) % 64], 3);

        // 3: TX_GAP=20, fill until the write stalls on full
        stalled = 1'b0;
        for (int k = 0; k < 40 && !stalled; k++) begin
            req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 4'h0; req_wdata[1] = $urandom;
            #1;
            if (req_ready[1] !== 1'b1) stalled = 1'b1;
            else do_req(1, 1'b1, 4'h0, req_wdata[1], 0);
        end
        req_valid[1] = 1'b0;
        chk("fill_stall", {31'b0, stalled}, 32'h1);
        do_req(1, 1'b0, 4'h4, 32'h0, 0);
        p0 = rd_n[1];
        do_req(1, 1'b1, 4'h0, $urandom, 0);
        chk("stall_until_pop", {31'b0, rd_n[1] > p0}, 32'h1);

        // 5: queue five chars, finish 0x05, then halt
        for (int k = 0; k < 5; k++) do_req(0, 1'b1, 4'h0, $urandom, 0);
        do_req(0, 1'b1, 4'h8, 32'hFFFF_FF05, 0);
        for (n = 0; n < 50 && !beat_seen[0]; n++) @(negedge clock);
        #1;
        chk("finish_beat", {31'b0, beat_seen[0]}, 32'h1);
        chk("finish_all_out", rd_n[0], wr_n[0]);
        snap = strobes[0]; hi = 0;
        req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = 4'h0; req_wdata[0] = 32'h41;
        repeat (50) begin
            @(negedge clock); #1;
            if (req_ready[0] !== 1'b0) hi++;
        end
        req_valid[0] = 1'b0;
        chk("halt_ready", hi, 0);
        chk("halt_strobes", strobes[0], snap);

        // 6: reset during DRAIN with characters pending
        reset = 1'b1; flush_model();
        @(posedge clock); @(negedge clock); reset = 1'b0;
        @(negedge clock); #1;
        for (int k = 0; k < 3; k++) do_req(1, 1'b1, 4'h0, $urandom, 0);
        do_req(1, 1'b1, 4'h8, 32'h0000_0003, 0);
        seen = 1'b0;
        for (n = 0; n < 60 && !seen; n++) begin
            @(negedge clock);
            if (uv[1] === 1'b1) seen = 1'b1;
        end
        chk("drain_strobe_seen", {31'b0, seen}, 32'h1);
        #1 reset = 1'b1; #1;
        chk("async_strobe_drop", {31'b0, uv[1]}, 32'h0);
        chk("async_ready_drop", {31'b0, req_ready[1]}, 32'h0);
        flush_model();
        @(posedge clock); @(negedge clock); reset = 1'b0;
        @(negedge clock); #1;
        do_req(1, 1'b0, 4'h4, 32'h0, 0);
        snap = strobes[1];
        repeat (60) @(negedge clock);
        #1;
        chk("no_beat_after_reset", strobes[1], snap);
        chk("no_finish_flag", {31'b0, beat_seen[1]}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
